// File: rtl/mac_pkg.sv
// Shared definitions for the MAC tile: width helpers, default sizing and the
// lane packing helper used for the flat din/weight buses.
package mac_pkg;

    // Default sizing of the tile
    localparam int LANES_DEF = 64;
    localparam int DIN_W_DEF = 4;
    localparam int WT_W_DEF  = 8;
    localparam int ACC_W_DEF = 32;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of one lane product: extended din times signed weight
    function automatic int prod_w(input int din_w, input int wt_w);
        return din_w + wt_w + 1;
    endfunction

    // Width of the full adder-tree result
    function automatic int sum_w(input int din_w, input int wt_w, input int lanes);
        return prod_w(din_w, wt_w) + clog2(lanes);
    endfunction

    // Bit offset of lane 'lane' in a flat bus of 'width'-bit lanes
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    localparam int PROD_W = prod_w(DIN_W_DEF, WT_W_DEF);
    localparam int SUM_W  = sum_w(DIN_W_DEF, WT_W_DEF, LANES_DEF);

endpackage

// File: rtl/mac_tile_acc_if.sv
// Beat input and result output bundle of the MAC tile.
interface mac_tile_acc_if #(
    parameter int LANES = 64,
    parameter int DIN_W = 4,
    parameter int WT_W  = 8,
    parameter int ACC_W = 32
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic                   din_signed;
    logic [DIN_W*LANES-1:0] din;
    logic [WT_W*LANES-1:0]  weight;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_ovf;

    // Producer of beats and consumer of results
    modport master (
        output in_valid, in_last, din_signed, din, weight, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // The tile itself
    modport slave (
        input  in_valid, in_last, din_signed, din, weight, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_add_tree.sv
// Registered binary adder tree: one register level per tree level, widths
// growing one bit per level so no level can overflow. Valid/last ride along.
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int IN_W  = PROD_W
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  en,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    input  logic [LANES*IN_W-1:0]                 in_data,
    output logic                                  out_valid,
    output logic                                  out_last,
    output logic signed [IN_W+clog2(LANES)-1:0]   out_data
);
    localparam int LEVELS = clog2(LANES);

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int W = IN_W + gi + 1;
            localparam int N = LANES >> (gi + 1);

            logic signed [W-1:0] sum_d [N];
            logic signed [W-1:0] sum_q [N];
            logic                valid_d, valid_q;
            logic                last_d, last_q;

            if (gi == 0) begin : g_first
                // Pairwise sums of the sign-extended lane products
                always_comb begin
                    for (int j = 0; j < N; j++) begin
                        sum_d[j] = W'($signed(in_data[lane_lsb(2*j, IN_W) +: IN_W]))
                                 + W'($signed(in_data[lane_lsb(2*j+1, IN_W) +: IN_W]));
                    end
                    valid_d = in_valid;
                    last_d  = in_last;
                end
            end else begin : g_next
                // Pairwise sums of the previous level, one bit wider
                always_comb begin
                    for (int j = 0; j < N; j++) begin
                        sum_d[j] = W'(g_lvl[gi-1].sum_q[2*j])
                                 + W'(g_lvl[gi-1].sum_q[2*j+1]);
                    end
                    valid_d = g_lvl[gi-1].valid_q;
                    last_d  = g_lvl[gi-1].last_q;
                end
            end

            // Level register, frozen while the tile is stalled
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int j = 0; j < N; j++) begin
                        sum_q[j] <= '0;
                    end
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else if (en) begin
                    sum_q   <= sum_d;
                    valid_q <= valid_d;
                    last_q  <= last_d;
                end
            end
        end
    endgenerate

    assign out_data  = g_lvl[LEVELS-1].sum_q[0];
    assign out_valid = g_lvl[LEVELS-1].valid_q;
    assign out_last  = g_lvl[LEVELS-1].last_q;

endmodule

// File: rtl/mac_tile_acc.sv
// Lane-tiled streaming MAC: product stage, registered adder tree, then an
// accumulator that closes a vector on the last beat and holds the result on a
// valid/ready output. A held, unaccepted result freezes the whole pipeline.
module mac_tile_acc
    import mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DIN_W = DIN_W_DEF,
    parameter int WT_W  = WT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    mac_tile_acc_if.slave bus
);
    localparam int LEVELS = clog2(LANES);
    localparam int PW     = prod_w(DIN_W, WT_W);
    localparam int TW     = PW + LEVELS;

    logic en;

    // Stage P state
    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic                 p_valid_d, p_valid_q;
    logic                 p_last_d, p_last_q;
    logic [LANES*PW-1:0]  prod_flat;

    // Tree output
    logic                 t_valid;
    logic                 t_last;
    logic signed [TW-1:0] t_sum;

    // Stage A state
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    ovf_d, ovf_q;
    logic                    out_valid_d, out_valid_q;
    logic signed [ACC_W-1:0] out_data_d, out_data_q;
    logic                    out_ovf_d, out_ovf_q;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    new_ovf;

    // Everything advances unless a result is held and not being taken
    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    // Per-lane product; din is zero- or sign-extended by one bit so the
    // product is always a signed PW-bit value
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic signed [DIN_W:0]  din_ext;
            logic signed [WT_W-1:0] wt_s;
            din_ext = {bus.din_signed & bus.din[lane_lsb(i, DIN_W) + DIN_W - 1],
                       bus.din[lane_lsb(i, DIN_W) +: DIN_W]};
            wt_s      = $signed(bus.weight[lane_lsb(i, WT_W) +: WT_W]);
            prod_d[i] = PW'(din_ext) * PW'(wt_s);
        end
        p_valid_d = bus.in_valid;
        p_last_d  = bus.in_valid & bus.in_last;
    end

    // Product register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
        end else if (en) begin
            prod_q    <= prod_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_flat
            assign prod_flat[gi*PW +: PW] = prod_q[gi];
        end
    endgenerate

    mac_add_tree #(
        .LANES (LANES),
        .IN_W  (PW)
    ) u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (p_valid_q),
        .in_last   (p_last_q),
        .in_data   (prod_flat),
        .out_valid (t_valid),
        .out_last  (t_last),
        .out_data  (t_sum)
    );

    // Accumulate tree sums, track signed overflow, close the vector on last
    always_comb begin
        sum_ext = ACC_W'(t_sum);
        acc_sum = acc_q + sum_ext;
        new_ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                  (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (en && t_valid) begin
            if (t_last) begin
                out_data_d  = acc_sum;
                out_ovf_d   = ovf_q | new_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = acc_sum;
                ovf_d = ovf_q | new_ovf;
            end
        end
    end

    // Accumulator and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
